fp_mult_sequencer: RTL

Parametrised operand sequencer for the floating-point multiplier path. It walks a synchronous operand memory of DEPTH entry pairs and issues each pair to an external multiplier using a start/done handshake. Each product is captured, with its index, into an internal result FIFO, which is drained by a slow consumer (LCD nibble path) over valid/ready. Generalises the fixed single-precision, pointer-increment controller: exponent and mantissa widths, depth, single-pass/loop mode and output buffering are all configurable.

---
 rtl/fp_seq_pkg.sv | 28 ++
 rtl/fp_mult_sequencer_if.sv | 29 ++
 rtl/fp_result_fifo.sv | 51 +++++
 rtl/fp_mult_sequencer.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/fp_seq_pkg.sv
// Shared types and helpers for the floating-point operand sequencer.
// Holds the FSM state encoding plus format-width and quiet-NaN helpers.
package fp_seq_pkg;

    localparam int MAX_FW = 128;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        ISSUE,
        WAIT,
        STORE
    } seq_state_t;

    function automatic int fw(input int exp_w, input int man_w);
        return 1 + exp_w + man_w;
    endfunction

    // Sign 0, exponent all ones, mantissa MSB set, remaining bits clear.
    function automatic logic [MAX_FW-1:0] qnan(input int exp_w, input int man_w);
        logic [MAX_FW-1:0] q;
        q = ((MAX_FW'(1) << exp_w) - MAX_FW'(1)) << man_w;
        q = q | (MAX_FW'(1) << (man_w - 1));
        return q;
    endfunction

endpackage

// File: rtl/fp_mult_sequencer_if.sv
// Operand memory, multiplier handshake and result stream of the sequencer.
// master = sequencer side, slave = memory / multiplier / consumer side.
interface fp_mult_sequencer_if #(
    parameter int FW = 32,
    parameter int AW = 4
);
    logic [AW-1:0] op_addr;
    logic [FW-1:0] op_a;
    logic [FW-1:0] op_b;
    logic          mult_start;
    logic [FW-1:0] mult_a;
    logic [FW-1:0] mult_b;
    logic [FW-1:0] mult_product;
    logic          mult_done;
    logic [FW-1:0] res_data;
    logic [AW-1:0] res_idx;
    logic          res_valid;
    logic          res_ready;

    modport master (
        output op_addr, mult_start, mult_a, mult_b, res_data, res_idx, res_valid,
        input  op_a, op_b, mult_product, mult_done, res_ready
    );

    modport slave (
        input  op_addr, mult_start, mult_a, mult_b, res_data, res_idx, res_valid,
        output op_a, op_b, mult_product, mult_done, res_ready
    );
endinterface

// File: rtl/fp_result_fifo.sv
// Count-based result FIFO; head entry is presented straight from storage.
// Storage is reset so the head reads zero after reset.
module fp_result_fifo #(
    parameter int W     = 36,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         valid,
    output logic         full
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [PW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head  = mem[rd_ptr];
    assign valid = (count != '0);
    assign full  = (count == (PW+1)'(DEPTH));
endmodule

// File: rtl/fp_mult_sequencer.sv
// Walks operand pairs through an external multiplier and queues the products.
// Optional SEQ_TIMEOUT_EN bounds WAIT and substitutes quiet NaN on expiry.
//
// state | meaning
// IDLE  | waiting for go
// FETCH | operand memory read in flight
// LOAD  | capture operands into mult_a/mult_b
// ISSUE | one-cycle mult_start
// WAIT  | waiting for mult_done (or timeout)
// STORE | push {product, index}; stall while FIFO full
module fp_mult_sequencer
    import fp_seq_pkg::*;
#(
    parameter int EXP_W     = 8,
    parameter int MAN_W     = 23,
    parameter int DEPTH     = 16,
    parameter int RES_DEPTH = 4,
    parameter int TIMEOUT   = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic go,
    input  logic loop_mode,
    input  logic stop,
    output logic busy,
    output logic run_done,
    output logic err_timeout,
    fp_mult_sequencer_if.master bus
);
    localparam int            FW   = fw(EXP_W, MAN_W);
    localparam int            AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    seq_state_t       state;
    seq_state_t       state_nxt;
    logic [AW-1:0]    addr;
    logic [FW-1:0]    opa_q;
    logic [FW-1:0]    opb_q;
    logic [FW-1:0]    prod_q;
    logic [FW+AW-1:0] head;
    logic             fifo_full;
    logic             push;
    logic             last_entry;
    logic             timed_out;
    logic [FW-1:0]    tmo_value;

`ifdef SEQ_TIMEOUT_EN
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    logic [TW-1:0] tmr;

    // Loaded in ISSUE so the first WAIT cycle already counts.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                         tmr <= '0;
        else if (state == ISSUE)            tmr <= TW'(TIMEOUT - 1);
        else if (state == WAIT && tmr != '0) tmr <= tmr - 1'b1;
    end

    assign timed_out = (state == WAIT) && !bus.mult_done && (tmr == '0);
    assign tmo_value = FW'(qnan(EXP_W, MAN_W));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                    err_timeout <= 1'b0;
        else if (state == IDLE && go)  err_timeout <= 1'b0;
        else if (timed_out)            err_timeout <= 1'b1;
    end
`else
    localparam int unused_timeout = TIMEOUT;

    assign timed_out   = 1'b0;
    assign tmo_value   = '0;
    assign err_timeout = 1'b0;
`endif

    assign last_entry = stop || (addr == LAST && !loop_mode);
    assign push       = (state == STORE) && !fifo_full;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (go) state_nxt = FETCH;
            FETCH:   state_nxt = LOAD;
            LOAD:    state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (bus.mult_done || timed_out) state_nxt = STORE;
            STORE:   if (!fifo_full) state_nxt = last_entry ? IDLE : FETCH;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.mult_start = (state == ISSUE);
        busy           = (state != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr     <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            prod_q   <= '0;
            run_done <= 1'b0;
        end else begin
            run_done <= push && last_entry;
            case (state)
                IDLE:  if (go) addr <= '0;
                LOAD: begin
                    opa_q <= bus.op_a;
                    opb_q <= bus.op_b;
                end
                WAIT: begin
                    if (bus.mult_done)  prod_q <= bus.mult_product;
                    else if (timed_out) prod_q <= tmo_value;
                end
                STORE: if (push && !last_entry) addr <= (addr == LAST) ? '0 : addr + 1'b1;
                default: ;
            endcase
        end
    end

    assign bus.op_addr = addr;
    assign bus.mult_a  = opa_q;
    assign bus.mult_b  = opb_q;

    fp_result_fifo #(
        .W     (FW + AW),
        .DEPTH (RES_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (reset),
        .push      (push),
        .push_data ({prod_q, addr}),
        .pop       (bus.res_ready),
        .head      (head),
        .valid     (bus.res_valid),
        .full      (fifo_full)
    );

    assign bus.res_data = head[FW+AW-1:AW];
    assign bus.res_idx  = head[AW-1:0];
endmodule
